riscv_ifetch: RTL and testbench

Instruction fetch unit that consumes the program counter and drives the instruction-memory request interface. It issues one fetch per PC value, stalls the PC register until each request is granted, and buffers returned instructions with their PCs in a small FIFO feeding decode. On a redirect (`flush_i`) it discards buffered and in-flight instructions.

---
 rtl/riscv_ifetch_if.sv | 28 ++
 rtl/riscv_ifetch.sv | 121 ++++++++++++
 tb/tb_riscv_ifetch.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_ifetch_if.sv
// Fetch-unit boundary: PC register handshake, instruction-memory bus and decode-side FIFO head.
// The master modport is the fetch unit; the slave modport is its environment.
interface riscv_ifetch_if #(
  parameter int DW = 32
);
  logic [DW-1:0] pc_i;
  logic          pc_stall_o;
  logic          flush_i;
  logic          imem_req_o;
  logic [DW-1:0] imem_addr_o;
  logic          imem_gnt_i;
  logic          imem_rvalid_i;
  logic [DW-1:0] imem_rdata_i;
  logic          id_stall_i;
  logic          inst_valid_o;
  logic [DW-1:0] inst_o;
  logic [DW-1:0] inst_pc_o;

  modport master (
    input  pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_stall_i,
    output pc_stall_o, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o
  );

  modport slave (
    output pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_stall_i,
    input  pc_stall_o, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o
  );
endinterface

// File: rtl/riscv_ifetch.sv
// Instruction fetch unit: one outstanding imem request per PC value, returned words
// queued with their PCs in a small FIFO for decode; a redirect drops everything older.
module riscv_ifetch #(
  parameter int DEPTH = 2,
  parameter int DW    = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  riscv_ifetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DROP
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] pend_pc_q;
  logic [DW-1:0] fifo_inst_q [DEPTH];
  logic [DW-1:0] fifo_pc_q   [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic has_room;
  logic req;
  logic grant;
  logic push;
  logic pop;

  // Space is checked at request time; with a single request in flight the
  // returning word always has a free slot.
  assign has_room = (count_q < CW'(DEPTH));
  assign req      = (state_q == S_FETCH) & has_room & ~bus.flush_i & ~rst_i;
  assign grant    = req & bus.imem_gnt_i;
  assign pop      = (count_q != '0) & ~bus.id_stall_i;

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = bus.pc_i;
  assign bus.pc_stall_o  = rst_i | ~(bus.flush_i | grant);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (grant) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rvalid_i) begin
          push    = ~bus.flush_i;
          state_d = S_FETCH;
        end else if (bus.flush_i) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        // The stale response is still owed by memory; swallow it before refetching.
        if (bus.imem_rvalid_i) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      pend_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) pend_pc_q <= bus.pc_i;
    end
  end

  // NOTE: the FIFO storage is reset because inst_o/inst_pc_o must read zero
  // straight after reset, even though inst_valid_o already gates them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else if (bus.flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_inst_q[wr_ptr_q] <= bus.imem_rdata_i;
        fifo_pc_q[wr_ptr_q]   <= pend_pc_q;
        wr_ptr_q              <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.inst_valid_o = (count_q != '0);
  assign bus.inst_o       = fifo_inst_q[rd_ptr_q];
  assign bus.inst_pc_o    = fifo_pc_q[rd_ptr_q];

  // A push into a full FIFO means the request gate was bypassed.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !bus.flush_i) begin
      assert (!(push && count_q == CW'(DEPTH)));
    end
  end
endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed bench for riscv_ifetch: a queue-based model of the fetch FIFO and the
// single outstanding request, a small PC register and a fixed-latency memory.
module tb_riscv_ifetch;
  localparam int DEPTH = 2;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  riscv_ifetch_if #(.DW(DW)) bus ();

  riscv_ifetch #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Scenario knobs
  bit          gnt_en       = 1'b1;
  int          rsp_lat      = 1;
  bit          id_stall     = 1'b0;
  bit          flush        = 1'b0;
  bit          spurious     = 1'b0;
  logic [31:0] flush_target = '0;

  // Environment: PC register and memory with one pending response
  logic [31:0] pc_reg   = '0;
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  // Model: FIFO contents plus whether a response is owed and whether it is stale
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;
  entry_t      q[$];
  bit          busy = 1'b0;
  bit          drop = 1'b0;
  logic [31:0] pend = '0;

  // Logs used by the literal expectations
  logic [31:0] pop_log[$];
  int          stall_low_cnt = 0;
  logic        last_req, last_stall, last_valid;
  logic [31:0] last_addr, last_inst, last_inst_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic apply_inputs();
    bit rsp_now;
    rsp_now           = mem_busy && (mem_cnt == 1);
    bus.pc_i          = pc_reg;
    bus.flush_i       = flush;
    bus.id_stall_i    = id_stall;
    bus.imem_gnt_i    = gnt_en;
    bus.imem_rvalid_i = rsp_now || spurious;
    bus.imem_rdata_i  = rsp_now ? inst_of(mem_addr) : 32'hDEAD_BEEF;
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance model and environment.
  task automatic tick();
    bit exp_req, exp_grant, exp_stall, rsp;
    apply_inputs();
    @(negedge clk);
    rsp       = (mem_busy && mem_cnt == 1) || spurious;
    exp_req   = !rst && !busy && (q.size() < DEPTH) && !flush;
    exp_grant = exp_req && gnt_en;
    exp_stall = rst || !(flush || exp_grant);

    check("imem_req", 32'(bus.imem_req_o), 32'(exp_req));
    check("imem_addr", bus.imem_addr_o, pc_reg);
    check("pc_stall", 32'(bus.pc_stall_o), 32'(exp_stall));
    check("inst_valid", 32'(bus.inst_valid_o), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("inst", bus.inst_o, q[0].inst);
      check("inst_pc", bus.inst_pc_o, q[0].pc);
    end

    last_req     = bus.imem_req_o;
    last_stall   = bus.pc_stall_o;
    last_valid   = bus.inst_valid_o;
    last_addr    = bus.imem_addr_o;
    last_inst    = bus.inst_o;
    last_inst_pc = bus.inst_pc_o;
    if (bus.inst_valid_o && !id_stall && !flush && !rst) pop_log.push_back(bus.inst_pc_o);
    if (!bus.pc_stall_o) stall_low_cnt++;

    if (rst) begin
      q.delete();
      busy = 1'b0;
      drop = 1'b0;
    end else begin
      if (flush) begin
        q.delete();
        if (busy && rsp) begin
          busy = 1'b0;
          drop = 1'b0;
        end else if (busy) begin
          drop = 1'b1;
        end
      end else begin
        if (q.size() != 0 && !id_stall) void'(q.pop_front());
        if (busy && rsp) begin
          if (!drop) q.push_back('{pc: pend, inst: inst_of(pend)});
          busy = 1'b0;
          drop = 1'b0;
        end
      end
      if (exp_grant) begin
        busy = 1'b1;
        drop = 1'b0;
        pend = pc_reg;
      end
    end

    if (rst) begin
      pc_reg   = '0;
      mem_busy = 1'b0;
    end else begin
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) mem_busy = 1'b0;
      end
      if (exp_grant) begin
        mem_busy = 1'b1;
        mem_cnt  = rsp_lat;
        mem_addr = pc_reg;
      end
      if (flush) pc_reg = flush_target;
      else if (!exp_stall) pc_reg = pc_reg + 32'd4;
    end

    @(posedge clk);
    #1;
    cycle++;
  endtask

  initial begin
    bus.pc_i          = '0;
    bus.flush_i       = 1'b0;
    bus.id_stall_i    = 1'b0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;

    // Reset
    rst = 1'b1;
    repeat (2) tick();
    check("rst_valid", 32'(last_valid), 32'h0);
    check("rst_inst", last_inst, 32'h0);
    check("rst_inst_pc", last_inst_pc, 32'h0);
    check("rst_req", 32'(last_req), 32'h0);
    stall_low_cnt = 0;

    // Streaming with 1-cycle grant and 1-cycle response
    rst = 1'b0;
    repeat (7) tick();
    check("t1_pops", pop_log.size(), 32'd3);
    check("t1_pop0", pop_log[0], 32'h0);
    check("t1_pop1", pop_log[1], 32'h4);
    check("t1_pop2", pop_log[2], 32'h8);
    check("t1_stall_low", stall_low_cnt, 32'd4);

    // Grant withheld for three cycles at PC 0x10
    gnt_en = 1'b0;
    tick();
    repeat (3) begin
      tick();
      check("t2_req_held", 32'(last_req), 32'h1);
      check("t2_addr_held", last_addr, 32'h10);
      check("t2_stall_held", 32'(last_stall), 32'h1);
    end
    gnt_en = 1'b1;
    tick();
    check("t2_grant_stall", 32'(last_stall), 32'h0);
    check("t2_grant_addr", last_addr, 32'h10);
    tick();

    // Decode stalled: FIFO fills to DEPTH and requests stop
    id_stall = 1'b1;
    repeat (3) tick();
    check("t3_req_drop", 32'(last_req), 32'h0);
    check("t3_model_fill", q.size(), 32'd2);
    check("t3_head", last_inst_pc, 32'h10);
    tick();
    id_stall = 1'b0;
    tick();
    check("t3_pop_a", last_inst_pc, 32'h10);
    check("t3_req_full", 32'(last_req), 32'h0);
    tick();
    check("t3_pop_b", last_inst_pc, 32'h14);
    check("t3_req_resume", 32'(last_req), 32'h1);
    repeat (3) tick();

    // Flush while waiting on the 0x20 response (arrives two cycles after grant)
    rsp_lat = 2;
    tick();
    check("t4_grant_addr", last_addr, 32'h20);
    flush        = 1'b1;
    flush_target = 32'h100;
    tick();
    flush = 1'b0;
    tick();
    check("t4_drop_valid", 32'(last_valid), 32'h0);
    tick();
    check("t4_redirect_addr", last_addr, 32'h100);
    rsp_lat = 1;
    repeat (2) tick();
    id_stall = 1'b1;
    tick();
    check("t4_head_pc", last_inst_pc, 32'h100);
    check("t4_head_inst", last_inst, 32'h5A5A_0113);

    // Flush in the same cycle as a response, FIFO non-empty
    flush        = 1'b1;
    flush_target = 32'h200;
    tick();
    flush = 1'b0;
    tick();
    check("t5_empty", 32'(last_valid), 32'h0);
    repeat (4) tick();
    check("t5_full", q.size(), 32'd2);
    flush        = 1'b1;
    flush_target = 32'h300;
    tick();
    flush_target = 32'h400;
    tick();
    check("t5_flush_no_req", 32'(last_req), 32'h0);
    check("t5_flush_empty", 32'(last_valid), 32'h0);
    flush    = 1'b0;
    id_stall = 1'b0;
    tick();
    check("t5_refetch_addr", last_addr, 32'h400);
    tick();

    // Response with nothing outstanding must be ignored
    gnt_en   = 1'b0;
    spurious = 1'b1;
    tick();
    check("t6_head", last_inst_pc, 32'h400);
    gnt_en   = 1'b1;
    spurious = 1'b0;
    rsp_lat  = 3;
    tick();
    check("t6_no_push", 32'(last_valid), 32'h0);

    // Reset while a response is outstanding
    rst = 1'b1;
    tick();
    check("t7_rst_req", 32'(last_req), 32'h0);
    check("t7_rst_stall", 32'(last_stall), 32'h1);
    rst     = 1'b0;
    rsp_lat = 1;
    tick();
    check("t7_valid", 32'(last_valid), 32'h0);
    check("t7_inst", last_inst, 32'h0);
    check("t7_inst_pc", last_inst_pc, 32'h0);
    check("t7_req", 32'(last_req), 32'h1);
    check("t7_addr", last_addr, 32'h0);
    repeat (2) tick();
    check("t7_first_valid", 32'(last_valid), 32'h1);
    check("t7_first_inst", last_inst, 32'h5A5A_0013);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
